store_image: RTL and testbench
==============================

# store_image

Write-back engine for the CNN datapath: drains a finished feature map from the on-chip pixel buffer to external memory in fixed 25-word blocks. It sits at the output of a layer and mirrors the image-load path, which pulls 25-word blocks in. The engine raises a write request per block and waits for memory acknowledge. It reports completion with a one-cycle done pulse.

## Interface
- MEM_ADDR_SIZE, 20, memory word-address width
- DATA_SIZE, 16, pixel width (signed two's complement)
- IMG_SIZE_WIDTH, 6, width of image side length
- BLOCK_SIZE, 25, words per memory write block
- MAX_PIXELS, 1024, depth of the pixel buffer input

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin write-back; sampled only in IDLE
- imgSize  in  IMG_SIZE_WIDTH  side length N; image is N*N pixels, row-major
- initialAddr  in  MEM_ADDR_SIZE  memory address of pixel 0
- image  in  DATA_SIZE x [0:MAX_PIXELS-1]  pixel buffer; held stable while busy
- memAck  in  1  memory accepted the current block
- address  out  MEM_ADDR_SIZE  block base address
- dataOut  out  DATA_SIZE x [0:BLOCK_SIZE-1]  block payload
- validCount  out  5  valid words in dataOut (1..25)
- write  out  1  write request
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, STAGE, WRITE, DONE.
- IDLE: on start, latch imgSize, initialAddr; total = N*N (12-bit, no truncation); blocks = ceil(total/25); blockIdx = 0; go STAGE. If N = 0, go DONE with no writes.
- STAGE (1 cycle): for i in 0..24, dataOut[i] <= image[blockIdx*25+i] if index < total, else 0. address <= initialAddr + blockIdx*25, modulo 2^MEM_ADDR_SIZE. validCount <= min(25, total - blockIdx*25). Go WRITE.
- WRITE: write = 1; address/dataOut/validCount held stable. When memAck is sampled high: if blockIdx = blocks-1, go DONE; else blockIdx++ and go STAGE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- start while busy: ignored. memAck outside WRITE: ignored.
- Never reads image beyond total-1; no over-read of a trailing block.

## Timing
- Reset values: address 0, dataOut all 0, validCount 0, write 0, busy 0, done 0, state IDLE.
- rst asserted mid-transfer: all of the above apply at that edge; the in-flight block is abandoned and done is not pulsed.
- With start sampled at edge E0: write visible after E1.
- Block k enters WRITE at E(2k+1) when memAck is tied high.
- With memAck held high, done is visible after edge E(2*blocks); busy falls one edge later.
- Each cycle memAck stays low adds one cycle to the current block.
- write falls on the edge that samples memAck high.
- There are no back-to-back writes: STAGE always separates consecutive writes.

## Configuration
- STORE_IMAGE_RELU_EN defined: STAGE clamps negative pixels (MSB set) to 0 before loading dataOut.
- STORE_IMAGE_RELU_EN undefined: pixels pass through unmodified.
- Control timing is identical in both builds.

## Structure
- Shared package cnn_mem_pkg holds:
  - the MEM_ADDR_SIZE, DATA_SIZE, BLOCK_SIZE and IMG_SIZE_WIDTH constants;
  - the state enum;
  - a pixel typedef, shared with the image-load path.
- One sub-module, block_stager: combinational slice select, zero-fill and optional ReLU for one block.
- store_image owns the FSM and counters, and registers the block_stager output in STAGE.

## Test plan
- N=5, initialAddr=0x00100, memAck high: one write at address 0x00100 with validCount 25 and dataOut = image[0..24]; done after edge E2.
- N=28, initialAddr=0: 32 writes at addresses 0, 25, …, 775; the last write has validCount 9 and words 9..24 equal to 0; done after edge E64.
- Backpressure, N=5: memAck low for 3 cycles, then high. write and dataOut stay stable for 4 cycles; done 3 cycles later than the no-stall case.
- N=0 start: no write pulse; busy high for exactly one cycle with done high in that cycle.
- Reset mid-operation, N=10: rst in the WRITE of block 2 drops all outputs to their reset values. A new start with N=5 then completes normally.
- Address wrap and ReLU: initialAddr=0xFFFF0 and N=10 wraps the second block address to 0x00009. A pixel of 0xFFF0 reads 0 with STORE_IMAGE_RELU_EN and 0xFFF0 without it.

Source files
------------

// File: rtl/cnn_mem_pkg.sv
// rtl/cnn_mem_pkg.sv - shared constants, types and helpers for the CNN image load/store paths
//
// Contents:
//   MEM_ADDR_SIZE, DATA_SIZE, IMG_SIZE_WIDTH, BLOCK_SIZE, MAX_PIXELS : geometry constants
//   PIX_CNT_W, PIX_IDX_W, VALID_W                                     : derived widths
//   pixel_t  : one pixel, two's complement (MSB is the sign)
//   state_e  : block-transfer FSM states
//   relu()   : clamp a negative pixel to zero
package cnn_mem_pkg;

  localparam int MEM_ADDR_SIZE  = 20;
  localparam int DATA_SIZE      = 16;
  localparam int IMG_SIZE_WIDTH = 6;
  localparam int BLOCK_SIZE     = 25;
  localparam int MAX_PIXELS     = 1024;

  // N*N needs twice the side-length width to avoid truncation.
  localparam int PIX_CNT_W = 2 * IMG_SIZE_WIDTH;
  localparam int PIX_IDX_W = $clog2(MAX_PIXELS);
  localparam int VALID_W   = 5;

  typedef logic signed [DATA_SIZE-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STAGE,
    ST_WRITE,
    ST_DONE
  } state_e;

  function automatic pixel_t relu(input pixel_t p);
    return p[DATA_SIZE-1] ? '0 : p;
  endfunction

endpackage

// File: rtl/block_stager.sv
// rtl/block_stager.sv - combinational slice select, zero-fill and optional ReLU for one block
//
// Optional feature macro: STORE_IMAGE_RELU_EN (clamp negative pixels to 0).
//
// Ports:
//   image_i        in  pixel buffer, MAX_PIXELS pixels
//   base_i         in  index of the first pixel of this block
//   total_i        in  number of valid pixels in the image (N*N)
//   words_o        out BLOCK_SIZE words; words past the image end read 0
//   valid_count_o  out number of valid words in words_o (1..BLOCK_SIZE)
module block_stager
  import cnn_mem_pkg::*;
(
  input  pixel_t               image_i [0:MAX_PIXELS-1],
  input  logic [PIX_CNT_W-1:0] base_i,
  input  logic [PIX_CNT_W-1:0] total_i,
  output pixel_t               words_o [0:BLOCK_SIZE-1],
  output logic [VALID_W-1:0]   valid_count_o
);

  logic [PIX_CNT_W-1:0] remaining;

  always_comb begin
    remaining = total_i - base_i;
    if (remaining >= PIX_CNT_W'(BLOCK_SIZE)) begin
      valid_count_o = VALID_W'(BLOCK_SIZE);
    end else begin
      valid_count_o = remaining[VALID_W-1:0];
    end
  end

  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_word
    logic [PIX_CNT_W:0] idx;
    logic               in_range;
    pixel_t             pix;

    assign idx = {1'b0, base_i} + (PIX_CNT_W + 1)'(g);
    // The buffer bound also guards images larger than the buffer, so the
    // index never leaves the array even when N*N exceeds MAX_PIXELS.
    assign in_range = (idx < {1'b0, total_i}) &&
                      (idx < (PIX_CNT_W + 1)'(MAX_PIXELS));
    assign pix = in_range ? image_i[idx[PIX_IDX_W-1:0]] : '0;

`ifdef STORE_IMAGE_RELU_EN
    assign words_o[g] = relu(pix);
`else
    assign words_o[g] = pix;
`endif
  end

endmodule

// File: rtl/store_image.sv
// rtl/store_image.sv - write-back engine draining the pixel buffer to memory in 25-word blocks
//
// Optional feature macro: STORE_IMAGE_RELU_EN (ReLU applied while staging a block).
//
// Ports:
//   clk_i          in  rising-edge clock
//   rst_i          in  synchronous active-high reset
//   start_i        in  begin write-back (sampled only in IDLE)
//   imgSize_i      in  image side length N (image is N*N pixels, row-major)
//   initialAddr_i  in  memory word address of pixel 0
//   image_i        in  pixel buffer, held stable while busy
//   memAck_i       in  memory accepted the current block
//   address_o      out block base address
//   dataOut_o      out block payload
//   validCount_o   out valid words in dataOut_o
//   write_o        out write request
//   busy_o         out high in every state except IDLE
//   done_o         out one-cycle completion pulse
module store_image
  import cnn_mem_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [IMG_SIZE_WIDTH-1:0] imgSize_i,
  input  logic [MEM_ADDR_SIZE-1:0]  initialAddr_i,
  input  pixel_t                    image_i [0:MAX_PIXELS-1],
  input  logic                      memAck_i,
  output logic [MEM_ADDR_SIZE-1:0]  address_o,
  output pixel_t                    dataOut_o [0:BLOCK_SIZE-1],
  output logic [VALID_W-1:0]        validCount_o,
  output logic                      write_o,
  output logic                      busy_o,
  output logic                      done_o
);

  state_e                   state_q, state_d;
  logic [PIX_CNT_W-1:0]     total_q, total_d;
  // base_q is blockIdx*BLOCK_SIZE, kept as a running sum instead of a multiply.
  logic [PIX_CNT_W-1:0]     base_q, base_d;
  logic [MEM_ADDR_SIZE-1:0] init_addr_q, init_addr_d;
  logic [MEM_ADDR_SIZE-1:0] address_q, address_d;
  pixel_t                   data_q [0:BLOCK_SIZE-1];
  pixel_t                   data_d [0:BLOCK_SIZE-1];
  logic [VALID_W-1:0]       valid_q, valid_d;

  pixel_t                   stage_words [0:BLOCK_SIZE-1];
  logic [VALID_W-1:0]       stage_valid;
  logic                     last_block;

  block_stager u_stager (
    .image_i       (image_i),
    .base_i        (base_q),
    .total_i       (total_q),
    .words_o       (stage_words),
    .valid_count_o (stage_valid)
  );

  // The current block is the last one when it holds all remaining pixels.
  assign last_block = (total_q - base_q) <= PIX_CNT_W'(BLOCK_SIZE);

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    base_d      = base_q;
    init_addr_d = init_addr_q;
    address_d   = address_q;
    data_d      = data_q;
    valid_d     = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          total_d     = PIX_CNT_W'(imgSize_i) * PIX_CNT_W'(imgSize_i);
          base_d      = '0;
          init_addr_d = initialAddr_i;
          state_d     = (imgSize_i == '0) ? ST_DONE : ST_STAGE;
        end
      end
      ST_STAGE: begin
        data_d    = stage_words;
        valid_d   = stage_valid;
        // Address arithmetic wraps modulo 2^MEM_ADDR_SIZE by width.
        address_d = init_addr_q + MEM_ADDR_SIZE'(base_q);
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (memAck_i) begin
          if (last_block) begin
            state_d = ST_DONE;
          end else begin
            base_d  = base_q + PIX_CNT_W'(BLOCK_SIZE);
            state_d = ST_STAGE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      total_q     <= '0;
      base_q      <= '0;
      init_addr_q <= '0;
      address_q   <= '0;
      data_q      <= '{default: '0};
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      base_q      <= base_d;
      init_addr_q <= init_addr_d;
      address_q   <= address_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  assign address_o    = address_q;
  assign dataOut_o    = data_q;
  assign validCount_o = valid_q;
  assign write_o      = (state_q == ST_WRITE);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_store_image.sv
// tb/tb_store_image.sv - self-checking bench for store_image against a block-list reference model
module tb_store_image;
  import cnn_mem_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [IMG_SIZE_WIDTH-1:0] img_size;
  logic [MEM_ADDR_SIZE-1:0]  init_addr;
  pixel_t                    image [0:MAX_PIXELS-1];
  logic                      mem_ack;
  logic [MEM_ADDR_SIZE-1:0]  address;
  pixel_t                    data_out [0:BLOCK_SIZE-1];
  logic [VALID_W-1:0]        valid_count;
  logic                      write;
  logic                      busy;
  logic                      done;

  int vectors = 0;
  int errors  = 0;

  int                       stall_tab [0:255];
  logic [MEM_ADDR_SIZE-1:0] addr_log  [0:255];
  pixel_t                   first_data [0:BLOCK_SIZE-1];

  always #5 clk = ~clk;

  store_image dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .imgSize_i     (img_size),
    .initialAddr_i (init_addr),
    .image_i       (image),
    .memAck_i      (mem_ack),
    .address_o     (address),
    .dataOut_o     (data_out),
    .validCount_o  (valid_count),
    .write_o       (write),
    .busy_o        (busy),
    .done_o        (done)
  );

  // Reference: word i of block b is pixel b*25+i if it exists, else 0.
  function automatic pixel_t model_word(input int total, input int blk, input int i);
    int     idx;
    pixel_t p;
    idx = blk * BLOCK_SIZE + i;
    if (idx >= total) return '0;
    p = image[idx];
`ifdef STORE_IMAGE_RELU_EN
    if (p < 0) p = '0;
`endif
    return p;
  endfunction

  task automatic randomize_image();
    for (int i = 0; i < MAX_PIXELS; i++) image[i] = pixel_t'($urandom);
  endtask

  // Runs one transfer; stall_mode >= 0 holds memAck low that many cycles per
  // block, -1 picks 0..3 at random. Outside WRITE memAck is randomised.
  task automatic run_xfer(input int n, input logic [MEM_ADDR_SIZE-1:0] init,
                          input int stall_mode,
                          output int done_edge, output int n_writes, output int last_valid);
    int total, blocks, exp_done, exp_start, blk, cyc, stall_sum;
    bit seen_done, finished;
    logic [MEM_ADDR_SIZE-1:0] exp_addr;
    int exp_valid;
    total = n * n;
    blocks = (total + BLOCK_SIZE - 1) / BLOCK_SIZE;
    stall_sum = 0;
    for (int k = 0; k < blocks; k++) begin
      stall_tab[k] = (stall_mode >= 0) ? stall_mode : int'($urandom_range(0, 3));
      stall_sum += stall_tab[k];
    end
    exp_done = 2 * blocks + stall_sum;
    exp_start = 1;
    blk = 0; cyc = 0; done_edge = -1; n_writes = 0; last_valid = -1;
    seen_done = 0; finished = 0;

    @(negedge clk);
    start = 1'b1;
    img_size = IMG_SIZE_WIDTH'(n);
    init_addr = init;
    mem_ack = 1'($urandom_range(0, 1));

    for (int e = 0; e < 2000 && !finished; e++) begin
      @(posedge clk);
      @(negedge clk);
      // start pulses while busy must be ignored.
      start = busy ? 1'($urandom_range(0, 1)) : 1'b0;

      if (seen_done) begin
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL idle_after_done n=%0d: busy=%b done=%b, required 0 0", n, busy, done);
        end
        finished = 1;
      end else if (done === 1'b1) begin
        seen_done = 1;
        done_edge = e;
        vectors++;
        if (e != exp_done || blk != blocks || busy !== 1'b1) begin
          errors++;
          $display("FAIL done_timing n=%0d: edge=%0d blocks_acked=%0d busy=%b, required edge=%0d blocks=%0d busy=1",
                   n, e, blk, busy, exp_done, blocks);
        end
      end

      if (write === 1'b1) begin
        if (blk >= blocks) begin
          vectors++; errors++;
          $display("FAIL extra_write n=%0d: write at edge %0d after %0d blocks", n, e, blocks);
          finished = 1;
        end else begin
          if (cyc == 0) begin
            vectors++;
            if (e != exp_start) begin
              errors++;
              $display("FAIL write_start n=%0d blk=%0d: edge=%0d, required %0d", n, blk, e, exp_start);
            end
            addr_log[blk] = address;
            if (blk == 0) first_data = data_out;
          end
          exp_addr = MEM_ADDR_SIZE'(init + MEM_ADDR_SIZE'(blk * BLOCK_SIZE));
          exp_valid = (total - blk * BLOCK_SIZE > BLOCK_SIZE) ? BLOCK_SIZE : total - blk * BLOCK_SIZE;
          vectors++;
          if (address !== exp_addr) begin
            errors++;
            $display("FAIL address n=%0d blk=%0d cyc=%0d: got %h, required %h", n, blk, cyc, address, exp_addr);
          end
          vectors++;
          if (valid_count !== VALID_W'(exp_valid)) begin
            errors++;
            $display("FAIL valid_count n=%0d blk=%0d: got %0d, required %0d", n, blk, valid_count, exp_valid);
          end
          for (int i = 0; i < BLOCK_SIZE; i++) begin
            vectors++;
            if (data_out[i] !== model_word(total, blk, i)) begin
              errors++;
              $display("FAIL data n=%0d blk=%0d word=%0d: got %h, required %h",
                       n, blk, i, data_out[i], model_word(total, blk, i));
            end
          end
          last_valid = int'(valid_count);
          if (cyc >= stall_tab[blk]) begin
            mem_ack = 1'b1;
            exp_start = e + 2;
            blk++; cyc = 0; n_writes++;
          end else begin
            mem_ack = 1'b0;
            cyc++;
          end
        end
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
    end

    if (!finished) begin
      vectors++; errors++;
      $display("FAIL timeout n=%0d: transfer did not complete, blocks acked %0d of %0d", n, blk, blocks);
    end
    start = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (address !== '0 || valid_count !== '0 || write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%h valid=%0d write=%b busy=%b done=%b, required all 0",
               address, valid_count, write, busy, done);
    end
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      vectors++;
      if (data_out[i] !== '0) begin
        errors++;
        $display("FAIL reset_data word=%0d: got %h, required 0", i, data_out[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_block();
    int de, nw, lv;
    randomize_image();
    run_xfer(5, 20'h00100, 0, de, nw, lv);
    vectors++;
    if (nw != 1 || de != 2 || lv != 25 || addr_log[0] !== 20'h00100) begin
      errors++;
      $display("FAIL single_block: writes=%0d done_edge=%0d valid=%0d addr=%h, required 1 2 25 00100",
               nw, de, lv, addr_log[0]);
    end
  endtask

  task automatic test_multi_block();
    int de, nw, lv;
    randomize_image();
    run_xfer(28, 20'h00000, 0, de, nw, lv);
    vectors++;
    if (nw != 32 || de != 64 || lv != 9 || addr_log[31] !== 20'd775 || addr_log[1] !== 20'd25) begin
      errors++;
      $display("FAIL multi_block: writes=%0d done_edge=%0d last_valid=%0d last_addr=%0d, required 32 64 9 775",
               nw, de, lv, addr_log[31]);
    end
  endtask

  task automatic test_backpressure();
    int de, nw, lv;
    randomize_image();
    run_xfer(5, 20'h00100, 3, de, nw, lv);
    vectors++;
    if (nw != 1 || de != 5) begin
      errors++;
      $display("FAIL backpressure: writes=%0d done_edge=%0d, required 1 5", nw, de);
    end
  endtask

  task automatic test_zero_size();
    int de, nw, lv;
    run_xfer(0, 20'h00040, 0, de, nw, lv);
    vectors++;
    if (nw != 0 || de != 0) begin
      errors++;
      $display("FAIL zero_size: writes=%0d done_edge=%0d, required 0 0", nw, de);
    end
  endtask

  task automatic test_reset_mid();
    int de, nw, lv, seen;
    bit hit;
    randomize_image();
    @(negedge clk);
    start = 1'b1; img_size = 6'd10; init_addr = 20'h00200; mem_ack = 1'b1;
    seen = 0; hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (write === 1'b1) begin
        if (seen == 2) hit = 1;
        else seen++;
      end
    end
    vectors++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach: writes seen %0d, required 3", seen);
    end
    rst = 1'b1;
    mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (address !== '0 || valid_count !== '0 || write !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || data_out[0] !== '0 || data_out[24] !== '0) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d: addr=%h valid=%0d write=%b busy=%b done=%b, required all 0",
                 c, address, valid_count, write, busy, done);
      end
    end
    rst = 1'b0;
    run_xfer(5, 20'h00300, 0, de, nw, lv);
    vectors++;
    if (nw != 1 || de != 2) begin
      errors++;
      $display("FAIL reset_mid_restart: writes=%0d done_edge=%0d, required 1 2", nw, de);
    end
  endtask

  task automatic test_wrap_relu();
    int de, nw, lv;
    pixel_t exp_px;
`ifdef STORE_IMAGE_RELU_EN
    exp_px = 16'h0000;
`else
    exp_px = 16'hFFF0;
`endif
    randomize_image();
    image[3] = 16'hFFF0;
    run_xfer(10, 20'hFFFF0, 1, de, nw, lv);
    vectors++;
    if (addr_log[0] !== 20'hFFFF0 || addr_log[1] !== 20'h00009 || nw != 4) begin
      errors++;
      $display("FAIL addr_wrap: blk0=%h blk1=%h writes=%0d, required FFFF0 00009 4",
               addr_log[0], addr_log[1], nw);
    end
    vectors++;
    if (first_data[3] !== exp_px) begin
      errors++;
      $display("FAIL relu_pixel: got %h, required %h", first_data[3], exp_px);
    end
  endtask

  task automatic test_random();
    int de, nw, lv;
    for (int r = 0; r < 6; r++) begin
      randomize_image();
      run_xfer(int'($urandom_range(1, 32)), MEM_ADDR_SIZE'($urandom), -1, de, nw, lv);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    img_size = '0;
    init_addr = '0;
    mem_ack = 1'b0;
    for (int i = 0; i < MAX_PIXELS; i++) image[i] = '0;

    test_reset();
    test_single_block();
    test_multi_block();
    test_backpressure();
    test_zero_size();
    test_reset_mid();
    test_wrap_relu();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
